// File: rtl/jtopl_pg_acc.sv
// Phase accumulator: scales the per-slot pure increment by MULT and accumulates a 19-bit phase per slot.
// Optional macro JTOPL_PG_HOLD_EN adds a pg_hold input that freezes the slot phase for the tick.
module jtopl_pg_acc #(
  parameter int NSLOTS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [17:0] phinc_pure,
  input  logic [3:0]  mul,
  input  logic        pg_rst,
`ifdef JTOPL_PG_HOLD_EN
  input  logic        pg_hold,
`endif
  output logic        zero,
  output logic [9:0]  phase_op
);

  localparam int SW   = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int PH_W = 19;
  localparam int IN_W = 22;

  // Doubled MULT factor so that mul=0 (x0.5) stays an integer multiply.
  function automatic logic [4:0] mul_x2(input logic [3:0] m);
    case (m)
      4'd0:    mul_x2 = 5'd1;
      4'd1:    mul_x2 = 5'd2;
      4'd2:    mul_x2 = 5'd4;
      4'd3:    mul_x2 = 5'd6;
      4'd4:    mul_x2 = 5'd8;
      4'd5:    mul_x2 = 5'd10;
      4'd6:    mul_x2 = 5'd12;
      4'd7:    mul_x2 = 5'd14;
      4'd8:    mul_x2 = 5'd16;
      4'd9:    mul_x2 = 5'd18;
      4'd10:   mul_x2 = 5'd20;
      4'd11:   mul_x2 = 5'd20;
      4'd12:   mul_x2 = 5'd24;
      4'd13:   mul_x2 = 5'd24;
      default: mul_x2 = 5'd30;
    endcase
  endfunction

  function automatic logic [IN_W-1:0] scale_inc(input logic [17:0] ph, input logic [3:0] m);
    logic [IN_W:0] prod;
    prod = {5'd0, ph} * {18'd0, mul_x2(m)};
    scale_inc = IN_W'(prod >> 1);
  endfunction

  logic [SW-1:0]   slot_p0;
  logic [SW-1:0]   slot_p1;
  logic [IN_W-1:0] inc_m_p1;
  logic            pg_rst_p1;
  logic            hold_p1;
  logic            vld_p1;
  logic [PH_W-1:0] phase [NSLOTS];
  logic [PH_W-1:0] phase_rd;
  logic [PH_W-1:0] nxt_phase;

  // Stage 0 -> 1: slot counter and multiplied increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_p0   <= '0;
      slot_p1   <= '0;
      inc_m_p1  <= '0;
      pg_rst_p1 <= 1'b0;
      vld_p1    <= 1'b0;
    end else if (cen) begin
      slot_p0   <= (slot_p0 == SW'(NSLOTS - 1)) ? '0 : slot_p0 + SW'(1);
      slot_p1   <= slot_p0;
      inc_m_p1  <= scale_inc(phinc_pure, mul);
      pg_rst_p1 <= pg_rst;
      vld_p1    <= 1'b1;
    end
  end

`ifdef JTOPL_PG_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      hold_p1 <= 1'b0;
    else if (cen) hold_p1 <= pg_hold;
  end
`else
  assign hold_p1 = 1'b0;
`endif

  always_comb begin
    phase_rd  = phase[slot_p1];
    nxt_phase = 19'({3'd0, phase_rd} + inc_m_p1);
    if (pg_rst_p1)
      nxt_phase = '0;
    else if (hold_p1)
      nxt_phase = phase_rd;
  end

  // Stage 1 -> 2: accumulate, write back and present the phase
  // vld_p1 keeps the first post-reset tick from emitting a stale slot-0 result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS; i++) phase[i] <= '0;
      phase_op <= '0;
      zero     <= 1'b0;
    end else if (cen && vld_p1) begin
      phase[slot_p1] <= nxt_phase;
      phase_op       <= nxt_phase[18:9];
      zero           <= (slot_p1 == '0);
    end
  end

endmodule

// File: tb/tb_jtopl_pg_acc.sv
// Scoreboard bench for jtopl_pg_acc: driver pushes hand-derived expectations, monitor pops per cen tick.
module tb_jtopl_pg_acc;

  localparam int NSL = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [17:0] phinc_pure = '0;
  logic [3:0]  mul = '0;
  logic        pg_rst = 1'b0;
`ifdef JTOPL_PG_HOLD_EN
  logic        pg_hold = 1'b0;
`endif
  logic        zero;
  logic [9:0]  phase_op;

  typedef struct packed {
    logic       chk;
    logic       z;
    logic [9:0] op;
  } exp_t;

  exp_t       sb[$];
  exp_t       ent;
  int         checks = 0;
  int         errors = 0;
  int         bslot = 0;
  int         mcnt = 0;
  logic [9:0] last_op = '0;
  logic       last_z = 1'b0;
  logic       mc, mr;

  // Per-frame deltas for phinc=0x100 and mul=slot (slots 16,17 use mul=1).
  logic [11:0] dtab [NSL] = '{12'h080, 12'h100, 12'h200, 12'h300, 12'h400, 12'h500,
                              12'h600, 12'h700, 12'h800, 12'h900, 12'hA00, 12'hA00,
                              12'hC00, 12'hC00, 12'hF00, 12'hF00, 12'h100, 12'h100};

  always #5 clk = ~clk;

  jtopl_pg_acc #(.NSLOTS(NSL)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .phinc_pure (phinc_pure),
    .mul        (mul),
    .pg_rst     (pg_rst),
`ifdef JTOPL_PG_HOLD_EN
    .pg_hold    (pg_hold),
`endif
    .zero       (zero),
    .phase_op   (phase_op)
  );

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Phase after f frames of -4 per frame, modulo 2^19, top 10 bits.
  function automatic logic [9:0] wrap_val(input int f);
    logic [19:0] p;
    p = 20'h80000 - 20'(4 * f);
    return p[18:9];
  endfunction

  function automatic logic [9:0] mult_val(input int s, input int f);
    int v;
    v = int'(dtab[s]) * f;
    return 10'(v >> 9);
  endfunction

  function automatic logic [3:0] mult_mul(input int s);
    return (s < 16) ? 4'(s) : 4'd1;
  endfunction

  task automatic tick(input logic [17:0] ph, input logic [3:0] m, input logic pr,
                      input logic [9:0] e, input logic chk);
    phinc_pure = ph;
    mul        = m;
    pg_rst     = pr;
    cen        = 1'b1;
    sb.push_back('{chk: chk, z: (bslot == 0), op: e});
    bslot = (bslot == NSL - 1) ? 0 : bslot + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: entry pushed for tick k is on the outputs after tick k+1.
  always @(posedge clk) begin
    mc = cen;
    mr = rst;
    #1;
    if (mr) begin
      mcnt    = 0;
      last_op = '0;
      last_z  = 1'b0;
    end else if (mc) begin
      mcnt++;
      if (mcnt == 1) begin
        check("first_tick_zero", {9'd0, zero}, 10'd0);
        check("first_tick_op", phase_op, 10'd0);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        ent     = sb.pop_front();
        last_op = ent.op;
        last_z  = ent.z;
        if (ent.chk) begin
          check("phase_op", phase_op, ent.op);
          check("zero", {9'd0, zero}, {9'd0, ent.z});
        end
      end
    end else if (mcnt >= 2) begin
      check("cen_hold_op", phase_op, last_op);
      check("cen_hold_zero", {9'd0, zero}, {9'd0, last_z});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int f = 1; f <= 4; f++)
      for (int s = 0; s < NSL; s++) tick(18'h00200, 4'd1, 1'b0, 10'(f), 1'b1);

    for (int s = 0; s < NSL; s++)
      tick(18'h00200, 4'd1, (s == 5), (s == 5) ? 10'd0 : 10'd5, 1'b1);
    for (int s = 0; s < NSL; s++)
      tick(18'h00200, 4'd1, 1'b0, (s == 5) ? 10'd1 : 10'd6, 1'b1);
    for (int s = 0; s < 7; s++)
      tick(18'h00200, 4'd1, 1'b0, (s == 5) ? 10'd2 : 10'd7, 1'b1);

    #2 rst = 1'b1;
    #1;
    check("async_rst_op", phase_op, 10'd0);
    check("async_rst_zero", {9'd0, zero}, 10'd0);
    sb.delete();
    bslot = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int f = 1; f <= 3; f++)
      for (int s = 0; s < NSL; s++) tick(18'h00100, mult_mul(s), 1'b0, mult_val(s, f), 1'b1);

    for (int s = 0; s < NSL; s++) tick(18'h00100, mult_mul(s), 1'b1, 10'd0, 1'b1);

    for (int f = 1; f <= 130; f++)
      for (int s = 0; s < NSL; s++) begin
        if (f == 3 && s == 9) begin
          cen = 1'b0;
          repeat (7) @(negedge clk);
        end
        tick(18'h3FFFF, 4'd4, 1'b0, wrap_val(f), 1'b1);
      end

`ifdef JTOPL_PG_HOLD_EN
    pg_hold = 1'b1;
    for (int s = 0; s < NSL; s++) tick(18'h3FFFF, 4'd4, 1'b0, wrap_val(130), 1'b1);
    pg_hold = 1'b0;
    for (int s = 0; s < NSL; s++) tick(18'h3FFFF, 4'd4, 1'b0, wrap_val(131), 1'b1);
`endif

    tick(18'h0, 4'd0, 1'b0, 10'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
